// File: rtl/tqvp_pwm_capture.sv
// tqvp_pwm_capture: TinyQV byte-bus peripheral that measures high time and
// period of a PWM waveform on one selectable ui_in pin, in clk cycles.
module tqvp_pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HI, S_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 r_state;
  logic                   r_en;
  logic                   r_hold;
  logic [2:0]             r_sel;
  logic                   r_valid;
  logic                   r_ovf;
  logic                   r_missed;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi_tmp;
  logic [CNT_W-1:0]       r_high;
  logic [CNT_W-1:0]       r_period;
  logic [7:0]             r_edges;

  logic        w_lvl, w_rise, w_fall;
  logic        w_wr_ctrl, w_wr_stat;
  logic        w_ctrl_off, w_resel, w_abort;
  logic        w_meas, w_ovf, w_done, w_load, w_miss;
  logic [15:0] w_high16, w_period16;
  logic        w_unused;

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  assign w_wr_ctrl = data_write && (address == 4'h0);
  assign w_wr_stat = data_write && (address == 4'h1);

  // A CTRL write that disables, or re-selects the pin while enabled,
  // abandons any measurement in progress.
  assign w_ctrl_off = w_wr_ctrl && !data_in[0];
  assign w_resel    = w_wr_ctrl && data_in[0] && r_en && (data_in[3:1] != r_sel);
  assign w_abort    = w_ctrl_off || w_resel;

  // Overflow beats any edge seen in the same cycle.
  assign w_meas = (r_state == S_HI) || (r_state == S_LO);
  assign w_ovf  = !w_abort && w_meas && (r_cnt == CNT_MAX);
  assign w_done = !w_abort && (r_state == S_LO) && w_rise && !w_ovf;
  assign w_load = w_done && !(r_hold && r_valid);
  assign w_miss = w_done && r_hold && r_valid;

  assign w_high16   = 16'(r_high);
  assign w_period16 = 16'(r_period);
  assign w_unused   = &{1'b0, data_in[7:5]};

  assign uo_out = {6'b0, w_lvl, r_valid};

  // Synchronizer for the selected pin plus one-cycle-delayed level for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1)
        r_sync <= {r_sync[SYNC_STAGES-2:0], ui_in[r_sel]};
      else
        r_sync <= ui_in[r_sel];
      r_prev <= w_lvl;
    end
  end

  // Measurement FSM: counter runs from the rising edge through HI and LO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi_tmp <= '0;
    end else if (w_abort) begin
      r_state <= w_ctrl_off ? S_IDLE : S_ARM;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_en) r_state <= S_ARM;
        end
        S_ARM: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (w_ovf) begin
            r_cnt   <= '0;
            r_state <= S_ARM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_fall) begin
              r_hi_tmp <= r_cnt + 1'b1;
              r_state  <= S_LO;
            end
          end
        end
        S_LO: begin
          if (w_ovf) begin
            r_cnt   <= '0;
            r_state <= S_ARM;
          end else if (w_rise) begin
            r_cnt   <= '0;
            r_state <= S_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control and status bits; a hardware set wins over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_sel    <= 3'd0;
      r_hold   <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= data_in[0];
        r_sel  <= data_in[3:1];
        r_hold <= data_in[4];
      end
      if (w_load)                       r_valid  <= 1'b1;
      else if (w_wr_stat && data_in[0]) r_valid  <= 1'b0;
      if (w_ovf)                        r_ovf    <= 1'b1;
      else if (w_wr_stat && data_in[1]) r_ovf    <= 1'b0;
      if (w_miss)                       r_missed <= 1'b1;
      else if (w_wr_stat && data_in[2]) r_missed <= 1'b0;
    end
  end

  // Shadow results, updated together so HIGH/PERIOD always form a pair
  always_ff @(posedge clk) begin
    if (rst) begin
      r_high   <= '0;
      r_period <= '0;
      r_edges  <= 8'd0;
    end else if (w_load) begin
      r_high   <= r_hi_tmp;
      r_period <= r_cnt + 1'b1;
      r_edges  <= r_edges + 8'd1;
    end
  end

  // Register read mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0: data_out = {3'b000, r_hold, r_sel, r_en};
      4'h1: data_out = {4'b0000, w_lvl, r_missed, r_ovf, r_valid};
      4'h2: data_out = w_high16[7:0];
      4'h3: data_out = w_high16[15:8];
      4'h4: data_out = w_period16[7:0];
      4'h5: data_out = w_period16[15:8];
      4'h6: data_out = r_edges;
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_pwm_capture.sv
// Testbench for tqvp_pwm_capture: directed scenarios plus random traffic,
// checked each cycle against a timestamp-based behavioural model.
module tb_tqvp_pwm_capture;
  localparam int SS = 2;
  localparam int CW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  tqvp_pwm_capture #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_write(data_write), .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Measurement is tracked as timestamps: rise time, fall time, now.
  bit         m_ok = 0;
  int         cyc = 0;
  logic       m_en, m_hold, m_valid, m_ovf, m_missed;
  logic [2:0] m_sel;
  int         m_high, m_period, m_edges;
  logic       m_q[$];
  logic       m_prev;
  int         m_mode;          // 0 off, 1 waiting for rise, 2 measuring
  int         t_rise, t_fall;
  bit         fall_seen;

  task automatic model_step();
    logic lvl, rise, fall, wc, ws, off, resel, abort, ovf_ev, done, load, miss;
    logic [7:0] d;
    cyc++;
    if (rst) begin
      m_en = 0; m_hold = 0; m_sel = 0;
      m_valid = 0; m_ovf = 0; m_missed = 0;
      m_high = 0; m_period = 0; m_edges = 0;
      m_q = {};
      for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
      m_prev = 0; m_mode = 0; t_rise = 0; t_fall = 0; fall_seen = 0;
      m_ok = 1;
      return;
    end
    lvl   = m_q[SS-1];
    rise  = lvl & ~m_prev;
    fall  = ~lvl & m_prev;
    d     = data_in;
    wc    = data_write && (address == 4'h0);
    ws    = data_write && (address == 4'h1);
    off   = wc && !d[0];
    resel = wc && d[0] && m_en && (d[3:1] != m_sel);
    abort = off || resel;
    ovf_ev = !abort && (m_mode == 2) && ((cyc - t_rise) == (1 << CW));
    done  = !abort && (m_mode == 2) && fall_seen && rise && !ovf_ev;
    load  = done && !(m_hold && m_valid);
    miss  = done && m_hold && m_valid;
    if (load) begin
      m_high   = t_fall - t_rise;
      m_period = cyc - t_rise;
      m_edges  = (m_edges + 1) % 256;
    end
    if (off) m_mode = 0;
    else if (resel) m_mode = 1;
    else begin
      case (m_mode)
        0: if (m_en) m_mode = 1;
        1: if (rise) begin m_mode = 2; t_rise = cyc; fall_seen = 0; end
        default: begin
          if (ovf_ev) m_mode = 1;
          else if (!fall_seen && fall) begin fall_seen = 1; t_fall = cyc; end
          else if (fall_seen && rise) begin t_rise = cyc; fall_seen = 0; end
        end
      endcase
    end
    m_valid  = load   ? 1'b1 : (ws && d[0]) ? 1'b0 : m_valid;
    m_ovf    = ovf_ev ? 1'b1 : (ws && d[1]) ? 1'b0 : m_ovf;
    m_missed = miss   ? 1'b1 : (ws && d[2]) ? 1'b0 : m_missed;
    m_q.push_front(ui_in[m_sel]);
    void'(m_q.pop_back());
    m_prev = lvl;
    if (wc) begin m_en = d[0]; m_sel = d[3:1]; m_hold = d[4]; end
  endtask

  function automatic logic [7:0] exp_uo();
    return {6'b0, m_q[SS-1], m_valid};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    case (a)
      4'h0: return {3'b000, m_hold, m_sel, m_en};
      4'h1: return {4'b0000, m_q[SS-1], m_missed, m_ovf, m_valid};
      4'h2: return 8'(m_high);
      4'h3: return 8'(m_high >> 8);
      4'h4: return 8'(m_period);
      4'h5: return 8'(m_period >> 8);
      4'h6: return 8'(m_edges);
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h want %02h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("uo_out", uo_out, exp_uo());
        chk($sformatf("data_out@%0h", address), data_out, exp_rd(address));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    data_write = 1'b0;
    address    = 4'($urandom_range(0, 7));
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    address = a;
    @(negedge clk);
    chk(nm, data_out, e);
    tick();
  endtask

  task automatic wave(input int pin, input int hi, input int lo, input int n, input bit noise);
    logic [7:0] v;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < hi + lo; c++) begin
        v = noise ? 8'($urandom) : 8'h00;
        v[pin] = (c < hi);
        ui_in = v;
        tick();
      end
    end
    ui_in = 8'h00;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst = 1'b1; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_uo", uo_out, 8'h00);
    for (int a = 0; a < 7; a++) rd(4'(a), 8'h00, "reset_reg");
    rst = 1'b0;
    tick();

    // 3 high / 5 low on pin 0
    wr(4'h0, 8'h01);
    repeat (4) tick();
    wave(0, 3, 5, 4, 0);
    repeat (6) tick();
    rd(4'h2, 8'h03, "sq_high_lo");
    rd(4'h3, 8'h00, "sq_high_hi");
    rd(4'h4, 8'h08, "sq_period_lo");
    rd(4'h5, 8'h00, "sq_period_hi");
    rd(4'h6, 8'h03, "sq_edges");
    @(negedge clk);
    chk("sq_uo", uo_out, 8'h01);

    // W1C, then W1C racing a completion
    tick();
    wr(4'h1, 8'h01);
    rd(4'h1, 8'h00, "w1c_clear");
    ui_in = 8'h01;
    tick();
    tick();
    wr(4'h1, 8'h01);
    rd(4'h1, 8'h09, "w1c_race");

    // overflow with the pin stuck high
    for (int k = 0; k < (1 << CW) + 10; k++) tick();
    rd(4'h1, 8'h0B, "ovf_status");
    rd(4'h2, 8'h03, "ovf_high_kept");
    wr(4'h1, 8'h02);
    ui_in = 8'h00;
    repeat (5) tick();
    wave(0, 10, 10, 3, 0);
    repeat (6) tick();
    rd(4'h2, 8'h0A, "resume_high");
    rd(4'h4, 8'h14, "resume_period");

    // HOLD blocks loading while VALID is set
    wave(0, 3, 5, 2, 0);
    repeat (3) tick();
    wr(4'h0, 8'h11);
    wave(0, 2, 6, 3, 0);
    repeat (6) tick();
    rd(4'h2, 8'h03, "hold_high");
    rd(4'h4, 8'h08, "hold_period");
    rd(4'h1, 8'h05, "hold_missed");
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h05);
    wave(0, 2, 6, 3, 0);
    repeat (6) tick();
    rd(4'h2, 8'h02, "unhold_high");
    rd(4'h4, 8'h08, "unhold_period");
    rd(4'h1, 8'h01, "unhold_status");

    // SEL=5 with noise on the other pins
    wr(4'h0, 8'h0B);
    repeat (4) tick();
    wave(5, 100, 156, 3, 1);
    repeat (6) tick();
    rd(4'h2, 8'h64, "sel5_high_lo");
    rd(4'h3, 8'h00, "sel5_high_hi");
    rd(4'h4, 8'h00, "sel5_period_lo");
    rd(4'h5, 8'h01, "sel5_period_hi");

    // reset in the middle of a high phase
    ui_in = 8'h20;
    repeat (10) tick();
    rst = 1'b1;
    ui_in = 8'h00;
    tick();
    @(negedge clk);
    chk("midrst_uo", uo_out, 8'h00);
    for (int a = 0; a < 7; a++) rd(4'(a), 8'h00, "midrst_reg");
    rst = 1'b0;
    wr(4'h0, 8'h01);
    repeat (4) tick();
    wave(0, 3, 5, 3, 0);
    repeat (6) tick();
    rd(4'h2, 8'h03, "rearm_high");
    rd(4'h4, 8'h08, "rearm_period");
    rd(4'h6, 8'h02, "rearm_edges");

    // random traffic against the model
    for (int it = 0; it < 150; it++) begin
      int op;
      logic [7:0] d;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        d = 8'($urandom);
        d[0] = ($urandom_range(0, 4) != 0);
        wr(4'h0, d);
      end else if (op == 1) begin
        wr(4'h1, 8'($urandom));
      end else if (op == 2) begin
        wr(4'($urandom_range(2, 15)), 8'($urandom));
      end else begin
        int pin;
        pin = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'(m_sel);
        wave(pin, $urandom_range(1, 20), $urandom_range(1, 20),
             $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end
    end
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
